// File: rtl/fifo_read_ctrl_fwft.sv
// Read-side FIFO controller: write-pointer sync, occupancy flags and
// standard or first-word-fall-through reads of a 1-cycle-latency memory.
module fifo_read_ctrl_fwft #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2,
    parameter int FWFT        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  clr_underflow,
    input  logic [ADDR_WIDTH:0]   wr_gray_ptr_async,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_gray_ptr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [PW-1:0]         sync_q [SYNC_STAGES];
    logic [PW-1:0]         wgray_sync;
    logic [PW-1:0]         wbin_sync;
    logic [PW-1:0]         mem_cnt;
    logic [PW-1:0]         rd_bin_q;
    logic [PW-1:0]         rd_bin_d;
    logic [PW-1:0]         rd_gray_q;
    logic [DATA_WIDTH-1:0] out_reg_q;
    logic                  out_vld_q;
    logic                  fetch_q;
    logic                  underflow_q;
    logic                  mem_ne;
    logic                  fetch;
    logic                  pop;

    assign wgray_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        wbin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            wbin_sync[i] = ^(wgray_sync >> i);
        end
    end

    assign mem_cnt  = wbin_sync - rd_bin_q;
    assign mem_ne   = (mem_cnt != '0);
    assign rd_bin_d = rd_bin_q + PW'(1);

    // fetch_q is the read-valid pipe in standard mode and the
    // in-flight flag in FWFT mode; both mean "memory data is live now".
    always_comb begin
        rd_valid = fetch_q;
        pop      = 1'b0;
        fetch    = !rst && rd_en && mem_ne;
        empty    = !mem_ne;
        rd_count = mem_cnt;
        if (FWFT != 0) begin
            rd_valid = out_vld_q | fetch_q;
            pop      = rd_en && rd_valid;
            fetch    = !rst && mem_ne && ((out_vld_q | fetch_q) == pop);
            empty    = !rd_valid;
            rd_count = mem_cnt + PW'(rd_valid);
        end
    end

    assign rd_data      = !rd_valid ? '0 :
                          (out_vld_q ? out_reg_q : mem_rdata);
    assign mem_rd_en    = fetch;
    assign rd_addr      = rd_bin_q[ADDR_WIDTH-1:0];
    assign rd_gray_ptr  = rd_gray_q;
    assign almost_empty = (rd_count <= AE_LVL);
    assign underflow    = underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            fetch_q     <= 1'b0;
            out_reg_q   <= '0;
            out_vld_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sync_q[0] <= wr_gray_ptr_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            fetch_q <= fetch;
            if (fetch) begin
                rd_bin_q  <= rd_bin_d;
                rd_gray_q <= rd_bin_d ^ (rd_bin_d >> 1);
            end
            // Park an unconsumed in-flight word so memory can be refetched.
            if (FWFT != 0 && fetch_q && !pop) begin
                out_reg_q <= mem_rdata;
                out_vld_q <= 1'b1;
            end else if (pop && out_vld_q) begin
                out_vld_q <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end else if (clr_underflow) begin
                underflow_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_read_ctrl_fwft.sv
// Bench: standard and FWFT instances on shared stimulus, checked against
// a word-count model every cycle plus hand-computed expectations.
module tb_fifo_read_ctrl_fwft;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int PW = AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic          clr = 1'b0;
    logic [PW-1:0] wr_g;

    logic          s_mre, s_valid, s_empty, s_ae, s_uf;
    logic [AW-1:0] s_addr;
    logic [PW-1:0] s_gray, s_cnt;
    logic [DW-1:0] s_data;
    logic [DW-1:0] s_mrd = '0;

    logic          f_mre, f_valid, f_empty, f_ae, f_uf;
    logic [AW-1:0] f_addr;
    logic [PW-1:0] f_gray, f_cnt;
    logic [DW-1:0] f_data;
    logic [DW-1:0] f_mrd = '0;

    logic [DW-1:0] wmem [16];
    logic [DW-1:0] wv [64];

    int wtot = 0;
    int epoch = 0;
    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: words are numbered by index; all state is plain counts.
    int s1 = 0, s2 = 0;
    int sF = 0, sVp = 0, su = 0;
    int fF = 0, fC = 0, fu = 0;

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] x;
        x = PW'(b % 32);
        return x ^ (x >> 1);
    endfunction

    assign wr_g = gray(wtot);

    always #5 clk = ~clk;

    fifo_read_ctrl_fwft #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2),
        .AE_THRESH(2), .FWFT(0)
    ) u_std (
        .clk(clk), .rst(rst), .rd_en(rd_en), .clr_underflow(clr),
        .wr_gray_ptr_async(wr_g), .mem_rdata(s_mrd),
        .mem_rd_en(s_mre), .rd_addr(s_addr), .rd_gray_ptr(s_gray),
        .rd_data(s_data), .rd_valid(s_valid), .empty(s_empty),
        .almost_empty(s_ae), .rd_count(s_cnt), .underflow(s_uf)
    );

    fifo_read_ctrl_fwft #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2),
        .AE_THRESH(2), .FWFT(1)
    ) u_fw (
        .clk(clk), .rst(rst), .rd_en(rd_en), .clr_underflow(clr),
        .wr_gray_ptr_async(wr_g), .mem_rdata(f_mrd),
        .mem_rd_en(f_mre), .rd_addr(f_addr), .rd_gray_ptr(f_gray),
        .rd_data(f_data), .rd_valid(f_valid), .empty(f_empty),
        .almost_empty(f_ae), .rd_count(f_cnt), .underflow(f_uf)
    );

    always @(posedge clk) begin
        if (s_mre) s_mrd <= wmem[s_addr];
        if (f_mre) f_mrd <= wmem[f_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int vis, scnt, pop;
        bit fv;
        vis = s2;
        if (rst) begin
            s1 = 0; s2 = 0;
            sF = 0; sVp = 0; su = 0;
            fF = 0; fC = 0; fu = 0;
        end else begin
            scnt = vis - sF;
            if (rd_en && scnt == 0) su = 1;
            else if (clr) su = 0;
            sVp = (rd_en && scnt > 0) ? 1 : 0;
            sF += sVp;
            fv = (fF > fC);
            pop = (rd_en && fv) ? 1 : 0;
            if (rd_en && !fv) fu = 1;
            else if (clr) fu = 0;
            fC += pop;
            if (fF == fC && vis > fF) fF++;
            s2 = s1;
            s1 = wtot;
        end
    end

    always @(negedge clk) begin
        int sc, fc, fpop;
        bit fv, fre;
        if (chk_en) begin
            sc = s2 - sF;
            chk("std.cnt", 32'(s_cnt), sc);
            chk("std.empty", 32'(s_empty), 32'(sc == 0));
            chk("std.ae", 32'(s_ae), 32'(sc <= 2));
            chk("std.valid", 32'(s_valid), sVp);
            if (sVp != 0 && sF > 0) chk("std.data", 32'(s_data), 32'(wv[sF-1]));
            chk("std.addr", 32'(s_addr), sF % 16);
            chk("std.gray", 32'(s_gray), 32'(gray(sF)));
            chk("std.mre", 32'(s_mre), 32'(!rst && rd_en && sc > 0));
            chk("std.uf", 32'(s_uf), su);
            fv = (fF > fC);
            fc = s2 - fC;
            fpop = (rd_en && fv) ? 1 : 0;
            fre = !rst && (fF - fC - fpop == 0) && (s2 > fF);
            chk("fw.valid", 32'(f_valid), 32'(fv));
            chk("fw.empty", 32'(f_empty), 32'(!fv));
            chk("fw.cnt", 32'(f_cnt), fc);
            chk("fw.ae", 32'(f_ae), 32'(fc <= 2));
            if (fv) chk("fw.data", 32'(f_data), 32'(wv[fC]));
            chk("fw.addr", 32'(f_addr), fF % 16);
            chk("fw.gray", 32'(f_gray), 32'(gray(fF)));
            chk("fw.mre", 32'(f_mre), 32'(fre));
            chk("fw.uf", 32'(f_uf), fu);
        end
    end

    task automatic tick(input bit r, input bit e, input bit c);
        rst = r; rd_en = e; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k);
        logic [DW-1:0] v;
        for (int j = 0; j < k; j++) begin
            v = DW'(wtot * 29 + epoch * 101 + 7);
            wv[wtot] = v;
            wmem[wtot % 16] = v;
            wtot++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) wmem[i] = '0;
        for (int i = 0; i < 64; i++) wv[i] = '0;
        wtot = 5;
        tick(1, 1, 0);
        chk_en = 1'b1;
        tick(1, 1, 0);
        chk("rst.s_empty", 32'(s_empty), 1);
        chk("rst.s_ae", 32'(s_ae), 1);
        chk("rst.s_cnt", 32'(s_cnt), 0);
        chk("rst.s_valid", 32'(s_valid), 0);
        chk("rst.s_gray", 32'(s_gray), 0);
        chk("rst.s_uf", 32'(s_uf), 0);
        chk("rst.f_empty", 32'(f_empty), 1);
        chk("rst.f_valid", 32'(f_valid), 0);
        chk("rst.f_data", 32'(f_data), 0);
        wtot = 0;

        push(3);
        tick(0, 0, 0);
        chk("lat.s_empty1", 32'(s_empty), 1);
        tick(0, 0, 0);
        chk("lat.s_empty2", 32'(s_empty), 0);
        chk("lat.s_cnt", 32'(s_cnt), 3);
        chk("lat.f_valid2", 32'(f_valid), 0);
        tick(0, 0, 0);
        chk("lat.f_valid3", 32'(f_valid), 1);
        chk("lat.f_data", 32'(f_data), 32'(wv[0]));
        chk("lat.f_cnt", 32'(f_cnt), 3);
        chk("rd.s_addr0", 32'(s_addr), 0);
        tick(0, 1, 0);
        chk("rd.s_addr1", 32'(s_addr), 1);
        chk("rd.s_gray1", 32'(s_gray), 1);
        chk("rd.s_valid", 32'(s_valid), 1);
        chk("rd.s_data0", 32'(s_data), 32'(wv[0]));
        chk("rd.f_data1", 32'(f_data), 32'(wv[1]));
        tick(0, 1, 0);
        chk("rd.s_addr2", 32'(s_addr), 2);
        chk("rd.s_gray2", 32'(s_gray), 3);
        tick(0, 1, 0);
        chk("rd.s_gray3", 32'(s_gray), 2);
        chk("rd.s_empty", 32'(s_empty), 1);
        chk("rd.s_data2", 32'(s_data), 32'(wv[2]));
        chk("rd.f_empty", 32'(f_empty), 1);

        tick(0, 1, 0);
        chk("uf.s_set", 32'(s_uf), 1);
        chk("uf.f_set", 32'(f_uf), 1);
        chk("uf.s_addr", 32'(s_addr), 3);
        tick(0, 1, 1);
        chk("uf.s_setwins", 32'(s_uf), 1);
        chk("uf.f_setwins", 32'(f_uf), 1);
        tick(0, 0, 1);
        chk("uf.s_clr", 32'(s_uf), 0);
        chk("uf.f_clr", 32'(f_uf), 0);

        push(4);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("ae.s_cnt4", 32'(s_cnt), 4);
        chk("ae.s_ae4", 32'(s_ae), 0);
        tick(0, 0, 0);
        chk("fw.valid", 32'(f_valid), 1);
        chk("fw.word0", 32'(f_data), 32'(wv[3]));
        chk("fw.cnt4", 32'(f_cnt), 4);
        chk("fw.ae4", 32'(f_ae), 0);
        for (int k = 1; k <= 4; k++) begin
            tick(0, 1, 0);
            chk("fw.cntk", 32'(f_cnt), 4 - k);
            chk("fw.aek", 32'(f_ae), (4 - k <= 2) ? 1 : 0);
            if (k < 4) begin
                chk("fw.validk", 32'(f_valid), 1);
                chk("fw.wordk", 32'(f_data), 32'(wv[3 + k]));
            end else begin
                chk("fw.emptyk", 32'(f_empty), 1);
            end
        end

        push(4);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 1, 0);
        chk("mid.f_word", 32'(f_data), 32'(wv[8]));
        wtot = 0;
        epoch++;
        tick(1, 0, 0);
        chk("mid.f_valid", 32'(f_valid), 0);
        chk("mid.f_empty", 32'(f_empty), 1);
        chk("mid.f_cnt", 32'(f_cnt), 0);
        chk("mid.f_gray", 32'(f_gray), 0);
        chk("mid.f_addr", 32'(f_addr), 0);
        chk("mid.f_ae", 32'(f_ae), 1);
        chk("mid.s_cnt", 32'(s_cnt), 0);
        chk("mid.s_valid", 32'(s_valid), 0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0);
            chk("mid.dropped", 32'(f_valid), 0);
        end

        for (int p = 0; p < 2; p++) begin
            push(16);
            tick(0, 0, 0);
            tick(0, 0, 0);
            chk("wrap.s_cnt16", 32'(s_cnt), 16);
            tick(0, 0, 0);
            chk("wrap.f_cnt16", 32'(f_cnt), 16);
            for (int k = 0; k < 16; k++) tick(0, 1, 0);
            tick(0, 0, 0);
            chk("wrap.s_gray", 32'(s_gray), (p == 0) ? 32'h18 : 32'h00);
            chk("wrap.f_gray", 32'(f_gray), (p == 0) ? 32'h18 : 32'h00);
            chk("wrap.s_addr", 32'(s_addr), 0);
            chk("wrap.f_addr", 32'(f_addr), 0);
            chk("wrap.s_empty", 32'(s_empty), 1);
            chk("wrap.f_empty", 32'(f_empty), 1);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
